// File: rtl/wb_intercon_pkg.sv
// wb_intercon_pkg: shared FSM encoding, default address map and timeout width for wb_intercon_nslave
package wb_intercon_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [15:0] RAM_MASK  = 16'h8000;
    localparam logic [15:0] UART_BASE = 16'hF000;
    localparam logic [15:0] UART_MASK = 16'hF000;
    localparam int TMO_W = 8;
endpackage

// File: rtl/wb_addr_match.sv
// wb_addr_match: base/mask compare per slave, lowest index wins on overlap
module wb_addr_match #(
    parameter int N_SLV = 2,
    parameter int AW = 16,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]    adr,
    output logic [N_SLV-1:0] hit_oh
);
    logic [N_SLV-1:0] hit;
    for (genvar g = 0; g < N_SLV; g++) begin : g_cmp
        assign hit[g] = (adr & SLV_MASK[g*AW +: AW]) == (SLV_BASE[g*AW +: AW] & SLV_MASK[g*AW +: AW]);
    end
    // isolating the lowest set bit gives the priority-encoded one-hot select
    assign hit_oh = hit & (~hit + N_SLV'(1));
endmodule

// File: rtl/wb_intercon_nslave.sv
// wb_intercon_nslave: single-master N-slave Wishbone decoder/mux; `define WB_TIMEOUT_EN adds a BUSY timeout
module wb_intercon_nslave
    import wb_intercon_pkg::*;
#(
    parameter int N_SLV = 2,
    parameter int AW = 16,
    parameter int DW = 16,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {UART_BASE, RAM_BASE},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {UART_MASK, RAM_MASK},
    parameter logic [N_SLV-1:0] SLV_FIXED = 2'b11,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_cyc_i,
    input  logic                m_stb_i,
    input  logic                m_we_i,
    input  logic [AW-1:0]       m_adr_i,
    input  logic [DW-1:0]       m_dat_i,
    output logic [DW-1:0]       m_dat_o,
    output logic                m_ack_o,
    output logic                m_err_o,
    output logic [N_SLV-1:0]    s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic [N_SLV*DW-1:0] s_dat_i,
    input  logic [N_SLV-1:0]    s_ack_i
);
    logic [1:0] state_q, state_d;
    logic [N_SLV-1:0] sel_q, sel_d, hit_oh, cyc;
    logic ack, err, busy_ack;
    logic [DW-1:0] dat;
`ifdef WB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    wb_addr_match #(.N_SLV(N_SLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_match (
        .adr(m_adr_i),
        .hit_oh(hit_oh)
    );

    // fixed slaves complete in their first BUSY cycle, the rest wait for their own ack
    assign busy_ack = |(sel_q & (SLV_FIXED | s_ack_i));

    // transaction FSM: accept in IDLE, complete/abort in BUSY, one-cycle error pulse in ERR
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        cyc = '0;
        ack = 1'b0;
        err = 1'b0;
`ifdef WB_TIMEOUT_EN
        tmo_d = tmo_q;
`endif
        if (state_q == ST_IDLE) begin
            if (m_cyc_i && m_stb_i) begin
                cyc = hit_oh;
                sel_d = hit_oh;
                state_d = |hit_oh ? ST_BUSY : ST_ERR;
`ifdef WB_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
        end else if (state_q == ST_BUSY) begin
            if (!m_cyc_i) begin
                state_d = ST_IDLE;
                sel_d = '0;
            end else begin
                cyc = sel_q;
                ack = busy_ack;
                if (busy_ack) begin
                    state_d = ST_IDLE;
                    sel_d = '0;
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    sel_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
        end else begin
            err = state_q == ST_ERR;
            state_d = ST_IDLE;
            sel_d = '0;
        end
    end

    // AND-OR read mux; sel_q is zero outside BUSY so idle data reads back as 0
    always_comb begin
        dat = '0;
        for (int i = 0; i < N_SLV; i++) dat = dat | (s_dat_i[i*DW +: DW] & {DW{sel_q[i]}});
    end

    assign m_ack_o = ack & ~rst;
    assign m_err_o = err & ~rst;
    assign s_cyc_o = rst ? '0 : cyc;
    assign m_dat_o = rst ? '0 : dat;
    assign s_stb_o = m_stb_i;
    assign s_we_o = m_we_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
`ifdef WB_TIMEOUT_EN
            tmo_q <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_intercon_nslave.sv
// tb_wb_intercon_nslave: randomized transactions against a transaction-level model of the interconnect
module tb_wb_intercon_nslave;
    localparam int TMO = 4;
    logic clk = 0, rst = 1;
    logic m_cyc_i = 0, m_stb_i = 0, m_we_i = 0;
    logic [15:0] m_adr_i = 0, m_dat_i = 0, m_dat_o, s_adr_o, s_dat_o;
    logic m_ack_o, m_err_o, s_stb_o, s_we_o;
    logic [1:0] s_cyc_o, s_ack_i = 0;
    logic [31:0] s_dat_i = 0;
    int checks = 0, errors = 0;
    logic [15:0] bas [2] = '{16'h0000, 16'hF000};
    logic [15:0] msk [2] = '{16'h8000, 16'hF000};
    logic [1:0] fx = 2'b01;

    wb_intercon_nslave #(
        .N_SLV(2), .AW(16), .DW(16),
        .SLV_BASE({16'hF000, 16'h0000}), .SLV_MASK({16'hF000, 16'h8000}),
        .SLV_FIXED(2'b01), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < 2; i++) if ((a & msk[i]) == (bas[i] & msk[i])) return i;
        return -1;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
        s_dat_i = $urandom;
    endtask

    task automatic idle_cycle();
        next();
        m_cyc_i = 0;
        m_stb_i = 0;
        s_ack_i = 2'($urandom);
        @(negedge clk);
        chk("idle_cyc", s_cyc_o, 0);
        chk("idle_ack", m_ack_o, 0);
        chk("idle_err", m_err_o, 0);
        chk("idle_dat", m_dat_o, 0);
    endtask

    // d: ack delay of an ack-driven slave in cycles after the request; ab: cycle the master aborts (0 = never)
    task automatic txn(input logic [15:0] adr, input logic we, input int d, input int ab);
        int idx;
        logic [1:0] oh;
        bit fixed, tmo, done, ack_now, err_now;
        idx = decode(adr);
        oh = (idx < 0) ? 2'b00 : 2'(1 << idx);
        fixed = idx >= 0 && fx[idx];
        tmo = 0;
`ifdef WB_TIMEOUT_EN
        tmo = idx >= 0 && !fixed && d > TMO;
`endif
        next();
        m_cyc_i = 1;
        m_stb_i = 1;
        m_we_i = we;
        m_adr_i = adr;
        m_dat_i = 16'($urandom);
        s_ack_i = 2'b11;
        @(negedge clk);
        chk("req_cyc", s_cyc_o, oh);
        chk("req_ack", m_ack_o, 0);
        chk("req_err", m_err_o, 0);
        chk("req_dat", m_dat_o, 0);
        chk("req_bcast", {s_stb_o, s_we_o, s_adr_o, s_dat_o}, {1'b1, we, adr, m_dat_i});
        if (idx < 0) begin
            next();
            m_cyc_i = 0;
            m_stb_i = 0;
            s_ack_i = 0;
            @(negedge clk);
            chk("unm_err", m_err_o, 1);
            chk("unm_ack", m_ack_o, 0);
            chk("unm_cyc", s_cyc_o, 0);
            return;
        end
        done = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            next();
            if (ab != 0 && k == ab) begin
                m_cyc_i = 0;
                m_stb_i = 0;
                s_ack_i = 0;
                @(negedge clk);
                chk("abort_cyc", s_cyc_o, 0);
                chk("abort_ack", m_ack_o, 0);
                chk("abort_err", m_err_o, 0);
                next();
                s_ack_i = 2'b11;
                @(negedge clk);
                chk("late_ack", m_ack_o, 0);
                chk("late_cyc", s_cyc_o, 0);
                s_ack_i = 0;
                return;
            end
            s_ack_i = ((!fixed && k == d) ? oh : 2'b00) | (2'($urandom) & fx);
            ack_now = fixed ? (k == 1) : (k == d && !tmo);
            err_now = tmo && k == TMO + 1;
            @(negedge clk);
            chk("busy_ack", m_ack_o, ack_now);
            chk("busy_err", m_err_o, err_now);
            chk("busy_cyc", s_cyc_o, err_now ? 2'b00 : oh);
            if (ack_now) chk("rd_dat", m_dat_o, s_dat_i[idx*16 +: 16]);
            done = ack_now || err_now;
        end
        if (!done) chk("bound", 0, 1);
    endtask

    task automatic rst_mid();
        txn_start_uart();
        next();
        rst = 1;
        s_ack_i = 2'b10;
        @(negedge clk);
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_dat", m_dat_o, 0);
        next();
        rst = 0;
        m_stb_i = 0;
        s_ack_i = 2'b10;
        @(negedge clk);
        chk("post_rst_cyc", s_cyc_o, 0);
        chk("post_rst_ack", m_ack_o, 0);
        idle_cycle();
    endtask

    task automatic txn_start_uart();
        next();
        m_cyc_i = 1;
        m_stb_i = 1;
        m_adr_i = 16'hF010;
        s_ack_i = 0;
        @(negedge clk);
        chk("rst_req_cyc", s_cyc_o, 2'b10);
    endtask

    initial begin
        int d, ab, lim;
        logic [15:0] a;
        m_cyc_i = 1;
        m_stb_i = 1;
        s_ack_i = 2'b11;
        @(negedge clk);
        chk("reset_cyc", s_cyc_o, 0);
        chk("reset_ack", m_ack_o, 0);
        chk("reset_err", m_err_o, 0);
        chk("reset_dat", m_dat_o, 0);
        @(posedge clk);
        #1;
        rst = 0;
        m_cyc_i = 0;
        m_stb_i = 0;
        s_ack_i = 0;
        idle_cycle();
        txn(16'h0123, 0, 1, 0);
        txn(16'hF001, 1, 1, 0);
        txn(16'h0002, 0, 1, 0);
        txn(16'h9000, 0, 1, 0);
        txn(16'hF000, 0, 3, 0);
        txn(16'hF004, 0, 5, 2);
        txn(16'h0040, 0, 1, 1);
        rst_mid();
        txn(16'hF008, 0, 22, 0);
        idle_cycle();
        for (int n = 0; n < 300; n++) begin
            a = 16'($urandom);
            d = $urandom_range(1, 7);
            ab = 0;
            if ($urandom_range(0, 4) == 0) begin
                if (decode(a) == 0) ab = 1;
                else if (d > 1) begin
                    lim = (d - 1 < TMO) ? d - 1 : TMO;
                    ab = $urandom_range(1, lim);
                end
            end
            txn(a, 1'($urandom), d, ab);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_intercon_nslave.md
Name: wb_intercon_nslave

Overview:
Parametrised single-master, N-slave Wishbone address decoder and read-data multiplexer. It sits between wb_j1_cpu and its peripherals (RAM, UART, future timers/GPIO) in the top level.
It replaces hard-wired per-slave select logic with a base/mask address map. Each slave is either fixed-latency or ack-driven, and unmapped accesses are answered with an error.
It tracks one outstanding transaction with a small FSM.

Parameters:
N_SLV, 2, number of slaves (1..8)
AW, 16, address width
DW, 16, data width
SLV_BASE, {16'hF000,16'h0000}, packed N_SLV*AW base addresses, slave 0 in LSBs
SLV_MASK, {16'hF000,16'h8000}, packed N_SLV*AW compare masks; hit = (adr & mask) == (base & mask)
SLV_FIXED, 2'b11, bit i=1: slave i has no ack, data valid 1 cycle after request; bit i=0: slave drives s_ack_i[i]
TIMEOUT, 255, max BUSY cycles before error (used only with WB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_we_i  in  1  master write enable
m_adr_i  in  AW  master address
m_dat_i  in  DW  master write data
m_dat_o  out  DW  read data to master
m_ack_o  out  1  transfer complete
m_err_o  out  1  unmapped/timeout error, 1-cycle pulse
s_cyc_o  out  N_SLV  per-slave cycle, one-hot or zero
s_stb_o  out  1  broadcast strobe (= m_stb_i)
s_we_o  out  1  broadcast write enable
s_adr_o  out  AW  broadcast address
s_dat_o  out  DW  broadcast write data
s_dat_i  in  N_SLV*DW  packed slave read data
s_ack_i  in  N_SLV  slave acks (ignored for SLV_FIXED slaves)

Behaviour:
- States: IDLE, BUSY, ERR. Registers: state, sel_r (one-hot N_SLV), optional tmo counter.
- Reset (and every cycle rst=1): state=IDLE, sel_r=0, counter=0. m_ack_o=0, m_err_o=0, m_dat_o=0, s_cyc_o=0.
- Decode (combinational): hit[i] per slave. On overlap, the lowest index wins (priority encoder). hit_oh is one-hot or zero.
- IDLE, m_cyc_i&m_stb_i=0: stay IDLE.
- IDLE, request with hit: s_cyc_o=hit_oh in the same cycle. sel_r<=hit_oh; go to BUSY.
- IDLE, request with no hit: no s_cyc_o; go to ERR.
- BUSY: s_cyc_o=sel_r while m_cyc_i=1.
  - Fixed slave: m_ack_o=1 in the first BUSY cycle, i.e. 1 cycle after the request.
  - Ack slave: m_ack_o=s_ack_i[sel] combinationally, earliest in the first BUSY cycle. s_ack_i seen in the IDLE request cycle is ignored.
  - On ack: go to IDLE and clear sel_r.
- m_dat_o = AND-OR mux of s_dat_i slices by sel_r. It is 0 when sel_r=0 and valid only while m_ack_o=1.
- ERR: m_err_o=1 for exactly one cycle, m_ack_o=0, then IDLE.
- Master drops m_cyc_i in BUSY: abort to IDLE, clear sel_r, no ack/err. A late slave ack is ignored.
- Back-to-back: a new request is accepted in the IDLE cycle right after ack/err, giving 2-cycle minimum throughput.
- m_ack_o and m_err_o are never both 1.

Optional Feature:
WB_TIMEOUT_EN
- Defined: 8-bit counter cleared on BUSY entry, incremented each BUSY cycle without ack. When it reaches TIMEOUT, the block goes to ERR (m_err_o pulse), drops s_cyc_o and clears sel_r.
- Undefined: no counter; BUSY waits indefinitely for ack or master abort.

Decomposition:
- Package wb_intercon_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, ERR=2'd2), default map constants (RAM_BASE=16'h0000/RAM_MASK=16'h8000, UART_BASE=16'hF000/UART_MASK=16'hF000), TMO_W=8.
- Sub-module wb_addr_match: per-slave base/mask compare plus lowest-index priority encoder, output hit_oh. Purely combinational.

Test Plan:
- Fixed RAM read: req adr=16'h0123, we=0, s_dat_i[0]=16'hBEEF. Expect s_cyc_o=2'b01 in cycle 0; m_ack_o=1 and m_dat_o=16'hBEEF in cycle 1; m_ack_o=0 in cycle 2.
- UART write: adr=16'hF001, m_dat_i=16'h0041. Expect s_cyc_o=2'b10, s_dat_o=16'h0041, m_ack_o in cycle 1. A back-to-back read of 16'h0002 starts in cycle 2.
- Unmapped: adr=16'h9000. Expect s_cyc_o=0 throughout, m_err_o=1 in cycle 1 only, m_ack_o=0.
- Ack-driven slave (SLV_FIXED=2'b01): slave 1 raises s_ack_i 3 cycles after request. Expect s_cyc_o[1] held, m_ack_o exactly in that cycle, then IDLE.
- Abort/reset: drop m_cyc_i in BUSY, then ack next cycle. Expect no m_ack_o. Separately, rst=1 mid-BUSY clears s_cyc_o and sel_r on the next edge.
- WB_TIMEOUT_EN, TIMEOUT=4, ack slave silent: expect m_err_o pulse after 4 BUSY cycles and s_cyc_o=0 after. Without the macro, BUSY persists for 20 cycles.
